// File: rtl/fp_add_mult.sv
// fp_add_mult: IEEE binary16 adder and multiplier on shared operands, RNE, flush-to-zero.
// Latency: 0 cycles (combinational); 1 cycle when macro FP_OUT_REG_EN is defined.
// Backpressure: none; a result pair is produced for every operand pair, every cycle.
module fp_add_mult #(
  parameter int BITS = 16  // only binary16 (16) is supported
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] iA,
  input  logic [BITS-1:0] iB,
  output logic [BITS-1:0] oAdd,
  output logic [BITS-1:0] oMul
);

  localparam logic [15:0] QNAN = 16'h7E00;

  // Operand decode; subnormals are flushed by giving them a zero significand.
  logic        sa, sb;
  logic [4:0]  ea, eb;
  logic [9:0]  fa, fb;
  logic        za, zb, ia, ib, na, nb;
  logic [10:0] ma, mb;

  assign sa = iA[15];
  assign sb = iB[15];
  assign ea = iA[14:10];
  assign eb = iB[14:10];
  assign fa = iA[9:0];
  assign fb = iB[9:0];
  assign za = (ea == 5'd0);
  assign zb = (eb == 5'd0);
  assign ia = (ea == 5'h1F) && (fa == 10'd0);
  assign ib = (eb == 5'h1F) && (fb == 10'd0);
  assign na = (ea == 5'h1F) && (fa != 10'd0);
  assign nb = (eb == 5'h1F) && (fb != 10'd0);
  assign ma = za ? 11'd0 : {1'b1, fa};
  assign mb = zb ? 11'd0 : {1'b1, fb};

  // ---------------------------------------------------------------- adder
  logic        swap, sx, sy;
  logic [4:0]  ex, ey, ediff;
  logic [10:0] mx, my;
  logic [3:0]  shamt, lead;
  logic [23:0] ext;
  logic [13:0] yal;
  logic [14:0] xal, sum, norm;
  logic [10:0] amant;
  logic        ag, ast;
  logic [11:0] arnd;
  logic [6:0]  aexp;
  logic [4:0]  afield;
  logic [9:0]  afrac;
  logic [15:0] add_d;

  // Adder: order by magnitude, align with sticky, add/sub, normalise, round, pack.
  always_comb begin
    swap  = {eb, mb} > {ea, ma};
    sx    = swap ? sb : sa;
    sy    = swap ? sa : sb;
    ex    = swap ? eb : ea;
    ey    = swap ? ea : eb;
    mx    = swap ? mb : ma;
    my    = swap ? ma : mb;
    ediff = ex - ey;
    shamt = (ediff > 5'd13) ? 4'd13 : ediff[3:0];
    // Frame is {significand, guard, round, sticky}; bits shifted below it jam into sticky.
    ext   = {my, 13'd0} >> shamt;
    yal   = ext[23:10] | {13'd0, |ext[9:0]};
    xal   = {1'b0, mx, 3'b000};
    sum   = (sx != sy) ? (xal - {1'b0, yal}) : (xal + {1'b0, yal});
    lead  = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (sum[i]) lead = 4'(i);
    end
    norm  = sum << (4'd14 - lead);
    amant = norm[14:4];
    ag    = norm[3];
    ast   = |norm[2:0];
    arnd  = {1'b0, amant} + {11'd0, ag & (ast | amant[0])};
    // Biased by +13: the larger operand's leading one sits at sum bit 13.
    aexp  = {2'b00, ex} + {3'b000, lead} + {6'd0, arnd[11]};
    afield = 5'(aexp - 7'd13);
    afrac = arnd[11] ? arnd[10:1] : arnd[9:0];

    add_d = {sx, afield, afrac};
    if (na || nb || (ia && ib && (sa != sb))) begin
      add_d = QNAN;
    end else if (ia) begin
      add_d = iA;
    end else if (ib) begin
      add_d = iB;
    end else if (sum == 15'd0) begin
      // Exact cancellation gives +0; only two negative zeros keep the sign.
      add_d = {sa & sb, 15'd0};
    end else if (aexp <= 7'd13) begin
      add_d = {sx, 15'd0};
    end else if (aexp >= 7'd44) begin
      add_d = {sx, 5'h1F, 10'd0};
    end
  end

  // ----------------------------------------------------------- multiplier
  logic        sm;
  logic [21:0] prod;
  logic [10:0] mmant;
  logic        mg, mst;
  logic [11:0] mrnd;
  logic [6:0]  mexp;
  logic [4:0]  mfield;
  logic [9:0]  mfrac;
  logic [15:0] mul_d;

  // Multiplier: 11x11 product, one-step normalise, round, pack with specials.
  always_comb begin
    sm   = sa ^ sb;
    prod = {11'd0, ma} * {11'd0, mb};
    if (prod[21]) begin
      mmant = prod[21:11];
      mg    = prod[10];
      mst   = |prod[9:0];
    end else begin
      mmant = prod[20:10];
      mg    = prod[9];
      mst   = |prod[8:0];
    end
    mrnd  = {1'b0, mmant} + {11'd0, mg & (mst | mmant[0])};
    // Biased by +15 so the test against the exponent range stays unsigned.
    mexp  = {2'b00, ea} + {2'b00, eb} + {6'd0, prod[21]} + {6'd0, mrnd[11]};
    mfield = 5'(mexp - 7'd15);
    mfrac = mrnd[11] ? mrnd[10:1] : mrnd[9:0];

    mul_d = {sm, mfield, mfrac};
    if (na || nb || (ia && zb) || (ib && za)) begin
      mul_d = QNAN;
    end else if (ia || ib) begin
      mul_d = {sm, 5'h1F, 10'd0};
    end else if (za || zb) begin
      mul_d = {sm, 15'd0};
    end else if (mexp <= 7'd15) begin
      mul_d = {sm, 15'd0};
    end else if (mexp >= 7'd46) begin
      mul_d = {sm, 5'h1F, 10'd0};
    end
  end

  // ---------------------------------------------------------- output stage
`ifdef FP_OUT_REG_EN
  logic [15:0] add_q, mul_q;

  // Output register: clears immediately on reset, captures both results each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_q <= 16'h0000;
      mul_q <= 16'h0000;
    end else begin
      add_q <= add_d;
      mul_q <= mul_d;
    end
  end

  assign oAdd = add_q;
  assign oMul = mul_q;
`else
  // Purely combinational build: clock and reset have no function here.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign oAdd = add_d;
  assign oMul = mul_d;
`endif

endmodule

// File: tb/tb_fp_add_mult.sv
// tb_fp_add_mult: directed and random checks of fp_add_mult against a real-arithmetic model.
// Latency: follows the DUT build (0 cycles, or 1 cycle with FP_OUT_REG_EN).
// Backpressure: none; one operand pair per clock.
module tb_fp_add_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] iA = 16'h0000;
  logic [15:0] iB = 16'h0000;
  logic [15:0] oAdd, oMul;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus-side state visible to the compare process.
  logic        cur_vld = 1'b0;
  logic        cur_lit = 1'b0;
  logic [15:0] cur_ladd = 16'h0000;
  logic [15:0] cur_lmul = 16'h0000;

  // One-cycle delayed copies for the registered build.
  logic [15:0] p_a = 16'h0000, p_b = 16'h0000, p_ladd = 16'h0000, p_lmul = 16'h0000;
  logic        p_vld = 1'b0, p_lit = 1'b0, p_rst = 1'b1;

  fp_add_mult #(.BITS(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .iA   (iA),
    .iB   (iB),
    .oAdd (oAdd),
    .oMul (oMul)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------- model
  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) begin
      for (int i = 0; i < e; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -e; i++) r = r / 2.0;
    end
    return r;
  endfunction

  // Value of a finite binary16 word, subnormals read as zero.
  function automatic real h2r(input logic [15:0] h);
    real m;
    if (h[14:10] == 5'd0) return 0.0;
    m = (1024.0 + real'(int'(h[9:0]))) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -m : m;
  endfunction

  // Round an exact real to binary16 (RNE at 11 bits, then range check).
  function automatic logic [15:0] r2h(input real x, input logic zsign);
    real ax, m, fr;
    int  e, q;
    logic s;
    logic [4:0] ef;
    logic [9:0] ff;
    if (x == 0.0) return {zsign, 15'd0};
    s  = (x < 0.0);
    ax = s ? -x : x;
    e  = 0;
    while (ax >= pow2(e + 1)) e++;
    while (ax < pow2(e)) e--;
    m  = ax / pow2(e - 10);
    q  = $rtoi(m);
    fr = m - q;
    if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q++;
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e < -14) return {s, 15'd0};
    if (e > 15) return {s, 5'h1F, 10'd0};
    ef = 5'(e + 15);
    ff = 10'(q - 1024);
    return {s, ef, ff};
  endfunction

  function automatic logic is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
  endfunction

  function automatic logic is_inf(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] == 10'd0);
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if (is_inf(a) && is_inf(b)) return (a[15] != b[15]) ? 16'h7E00 : a;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    return r2h(h2r(a) + h2r(b), (a[15] == b[15]) ? a[15] : 1'b0);
  endfunction

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic zsa, zsb;
    zsa = (a[14:10] == 5'd0);
    zsb = (b[14:10] == 5'd0);
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if ((is_inf(a) && zsb) || (is_inf(b) && zsa)) return 16'h7E00;
    if (is_inf(a) || is_inf(b)) return {a[15] ^ b[15], 15'h7C00};
    return r2h(h2r(a) * h2r(b), a[15] ^ b[15]);
  endfunction

  task automatic chk(input string name, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s a=%h b=%h got=%h expected=%h", name, a, b, act, exp);
    end
  endtask

  // ------------------------------------------------------------ compare
  always @(posedge clk) begin
    p_a    <= iA;
    p_b    <= iB;
    p_vld  <= cur_vld;
    p_lit  <= cur_lit;
    p_ladd <= cur_ladd;
    p_lmul <= cur_lmul;
    p_rst  <= !rst_n;
  end

  always @(negedge clk) begin
`ifdef FP_OUT_REG_EN
    if (!rst_n || p_rst) begin
      chk("reset_add", p_a, p_b, oAdd, 16'h0000);
      chk("reset_mul", p_a, p_b, oMul, 16'h0000);
    end else if (p_vld) begin
      chk("add", p_a, p_b, oAdd, ref_add(p_a, p_b));
      chk("mul", p_a, p_b, oMul, ref_mul(p_a, p_b));
      if (p_lit) begin
        chk("lit_add", p_a, p_b, oAdd, p_ladd);
        chk("lit_mul", p_a, p_b, oMul, p_lmul);
      end
    end
`else
    if (cur_vld) begin
      chk("add", iA, iB, oAdd, ref_add(iA, iB));
      chk("mul", iA, iB, oMul, ref_mul(iA, iB));
      if (cur_lit) begin
        chk("lit_add", iA, iB, oAdd, cur_ladd);
        chk("lit_mul", iA, iB, oMul, cur_lmul);
      end
    end
`endif
  end

  // ----------------------------------------------------------- stimulus
  // {a, b, a+b, a*b}, all hand-computed.
  localparam logic [63:0] DIR [16] = '{
    64'h3C00_4000_4200_4000, 64'h4000_4200_4500_4600,
    64'h3C00_BC00_0000_BC00, 64'h3C00_1000_3C00_1000,
    64'h3C01_1000_3C02_1001, 64'h7BFF_7BFF_7C00_7C00,
    64'h7C00_FC00_7E00_FC00, 64'h0000_7C00_7C00_7E00,
    64'h0001_3C00_3C00_0000, 64'h8000_8000_8000_0000,
    64'h7C01_3C00_7E00_7E00, 64'h0400_0400_0800_0000,
    64'h8400_0400_0000_8000, 64'h0400_8401_8000_8000,
    64'hFC00_4000_FC00_FC00, 64'h7BFF_8001_7BFF_8000
  };

  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic lit,
                       input logic [15:0] la, input logic [15:0] lm);
    @(posedge clk);
    #1;
    iA       = a;
    iB       = b;
    cur_vld  = 1'b1;
    cur_lit  = lit;
    cur_ladd = la;
    cur_lmul = lm;
  endtask

  task automatic rand_vectors(input int n);
    logic [15:0] a, b;
    for (int k = 0; k < n; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b[14:10] = a[14:10];
        1: b = {~a[15], a[14:0] ^ 15'($urandom_range(0, 7))};
        default: ;
      endcase
      apply(a, b, 1'b0, 16'h0000, 16'h0000);
    end
  endtask

  initial begin
    logic [63:0] ent;
    #1;
`ifdef FP_OUT_REG_EN
    chk("por_add", iA, iB, oAdd, 16'h0000);
    chk("por_mul", iA, iB, oMul, 16'h0000);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      ent = DIR[i];
      chk("model_pin_add", ent[63:48], ent[47:32], ref_add(ent[63:48], ent[47:32]), ent[31:16]);
      chk("model_pin_mul", ent[63:48], ent[47:32], ref_mul(ent[63:48], ent[47:32]), ent[15:0]);
      apply(ent[63:48], ent[47:32], 1'b1, ent[31:16], ent[15:0]);
    end

    rand_vectors(5000);

`ifdef FP_OUT_REG_EN
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_add", iA, iB, oAdd, 16'h0000);
    chk("async_rst_mul", iA, iB, oMul, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
`endif

    rand_vectors(5000);

    @(posedge clk);
    #1;
    cur_vld = 1'b0;
    cur_lit = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
